gmii_tx_framer: RTL and testbench

Byte-stream to GMII transmit framer in the `gmii_tx_clk` domain. It takes raw Ethernet frame bytes (destination MAC through end of payload) over a valid/ready handshake. It emits preamble, SFD, payload, optional zero padding, CRC-32 FCS and inter-frame gap onto the GMII bus that feeds `gmii_to_rgmii`. Frame generators such as `eth_send_frame` or an ARP builder sit upstream and supply only the MAC frame contents.

---
 rtl/gmii_tx_framer.sv | 214 +++++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: wraps a raw MAC frame byte stream into a GMII transmit frame
// (preamble, SFD, payload, optional zero pad, CRC-32 FCS, inter-frame gap).
// Optional feature macro: GMII_TX_PAD_EN -- when defined, frames shorter than
// MIN_FRAME bytes are zero-padded before the FCS.
module gmii_tx_framer #(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_FRAME  = 60
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_tx_data,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, ERR, IFG} state_t;

  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [2:0]  pre_cnt_reg, pre_cnt_next;
  logic [7:0]  ifg_cnt_reg, ifg_cnt_next;
  logic [1:0]  fcs_idx_reg, fcs_idx_next;
  logic [31:0] crc_reg, crc_next;
  logic [10:0] byte_cnt_reg, byte_cnt_next;
  logic [10:0] cnt_inc;
  logic        last_seen_reg, last_seen_next;
  logic [7:0]  tx_data_next;
  logic        tx_en_next, tx_er_next, frame_done_next, underrun_next;
  logic        enter_fcs;
  logic [7:0]  fcs_byte [4];

`ifdef GMII_TX_PAD_EN
  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
`else
  logic [10:0] unused_min_frame;
  assign unused_min_frame = 11'(MIN_FRAME);
`endif

  // Reflected IEEE 802.3 CRC-32, one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // FCS is the inverted CRC, sent least-significant byte first.
  for (genvar gi = 0; gi < 4; gi++) begin : g_fcs
    assign fcs_byte[gi] = ~crc_reg[8*gi +: 8];
  end

  assign cnt_inc = (byte_cnt_reg == 11'h7FF) ? byte_cnt_reg : byte_cnt_reg + 11'd1;
  assign s_ready = (state_reg == SFD) || ((state_reg == DATA) && !last_seen_reg);
  assign busy    = (state_reg != IDLE);

  // Next state plus the GMII byte that the next state will drive.
  always_comb begin
    state_next      = state_reg;
    pre_cnt_next    = pre_cnt_reg;
    ifg_cnt_next    = ifg_cnt_reg;
    fcs_idx_next    = fcs_idx_reg;
    crc_next        = crc_reg;
    byte_cnt_next   = byte_cnt_reg;
    last_seen_next  = last_seen_reg;
    tx_data_next    = 8'h00;
    tx_en_next      = 1'b0;
    tx_er_next      = 1'b0;
    frame_done_next = 1'b0;
    underrun_next   = 1'b0;
    enter_fcs       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_valid) begin
          state_next   = PRE;
          pre_cnt_next = 3'd0;
          tx_data_next = 8'h55;
          tx_en_next   = 1'b1;
        end
      end
      PRE: begin
        tx_en_next = 1'b1;
        if (pre_cnt_reg == 3'd6) begin
          state_next     = SFD;
          tx_data_next   = 8'hD5;
          crc_next       = 32'hFFFF_FFFF;
          byte_cnt_next  = 11'd0;
          last_seen_next = 1'b0;
        end else begin
          pre_cnt_next = pre_cnt_reg + 3'd1;
          tx_data_next = 8'h55;
        end
      end
      SFD, DATA: begin
        if ((state_reg == DATA) && last_seen_reg) begin
`ifdef GMII_TX_PAD_EN
          if (byte_cnt_reg < MIN_CNT) begin
            state_next    = PAD;
            tx_en_next    = 1'b1;
            crc_next      = crc32_byte(crc_reg, 8'h00);
            byte_cnt_next = cnt_inc;
          end else begin
            enter_fcs = 1'b1;
          end
`else
          enter_fcs = 1'b1;
`endif
        end else if (s_valid) begin
          state_next     = DATA;
          tx_data_next   = s_data;
          tx_en_next     = 1'b1;
          crc_next       = crc32_byte(crc_reg, s_data);
          byte_cnt_next  = cnt_inc;
          last_seen_next = s_last;
        end else begin
          state_next    = ERR;
          tx_en_next    = 1'b1;
          tx_er_next    = 1'b1;
          underrun_next = 1'b1;
        end
      end
`ifdef GMII_TX_PAD_EN
      PAD: begin
        if (byte_cnt_reg >= MIN_CNT) begin
          enter_fcs = 1'b1;
        end else begin
          tx_en_next    = 1'b1;
          crc_next      = crc32_byte(crc_reg, 8'h00);
          byte_cnt_next = cnt_inc;
        end
      end
`endif
      FCS: begin
        if (fcs_idx_reg == 2'd3) begin
          state_next      = IFG;
          ifg_cnt_next    = 8'd0;
          frame_done_next = 1'b1;
        end else begin
          fcs_idx_next = fcs_idx_reg + 2'd1;
          tx_data_next = fcs_byte[fcs_idx_reg + 2'd1];
          tx_en_next   = 1'b1;
        end
      end
      ERR: begin
        state_next   = IFG;
        ifg_cnt_next = 8'd0;
      end
      IFG: begin
        if (ifg_cnt_reg == IFG_LAST) begin
          // A frame already waiting starts straight from the last gap cycle
          // so back-to-back frames see exactly IFG_CYCLES idle bytes.
          if (s_valid) begin
            state_next   = PRE;
            pre_cnt_next = 3'd0;
            tx_data_next = 8'h55;
            tx_en_next   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          ifg_cnt_next = ifg_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (enter_fcs) begin
      state_next   = FCS;
      fcs_idx_next = 2'd0;
      tx_data_next = fcs_byte[0];
      tx_en_next   = 1'b1;
    end
  end

  // State, datapath and registered GMII outputs.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pre_cnt_reg   <= 3'd0;
      ifg_cnt_reg   <= 8'd0;
      fcs_idx_reg   <= 2'd0;
      crc_reg       <= 32'hFFFF_FFFF;
      byte_cnt_reg  <= 11'd0;
      last_seen_reg <= 1'b0;
      gmii_tx_data  <= 8'h00;
      gmii_tx_en    <= 1'b0;
      gmii_tx_er    <= 1'b0;
      frame_done    <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pre_cnt_reg   <= pre_cnt_next;
      ifg_cnt_reg   <= ifg_cnt_next;
      fcs_idx_reg   <= fcs_idx_next;
      crc_reg       <= crc_next;
      byte_cnt_reg  <= byte_cnt_next;
      last_seen_reg <= last_seen_next;
      gmii_tx_data  <= tx_data_next;
      gmii_tx_en    <= tx_en_next;
      gmii_tx_er    <= tx_er_next;
      frame_done    <= frame_done_next;
      underrun      <= underrun_next;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: randomized frames checked against a table-driven CRC
// reference model of the expected GMII byte sequence.
module tb_gmii_tx_framer;

  localparam int IFG  = 12;
  localparam int MINF = 60;
`ifdef GMII_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic       gmii_tx_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [7:0] gmii_tx_data;
  logic       gmii_tx_en, gmii_tx_er, busy, frame_done, underrun;

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  gmii_tx_framer #(.IFG_CYCLES(IFG), .MIN_FRAME(MINF)) dut (
    .gmii_tx_clk (gmii_tx_clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .gmii_tx_data(gmii_tx_data),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  typedef struct packed {
    logic [7:0] d;
    logic en; logic er; logic fd; logic ur; logic bz; logic rdy; logic sv; logic acc_last;
  } rec_t;

  rec_t        rec_q[$];
  bit          rec_on = 1'b0;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] crc_tab [256];
  int          run_st[$];
  int          run_ln[$];

  // Capture one record per cycle on the falling edge.
  always @(negedge gmii_tx_clk) begin
    if (rec_on)
      rec_q.push_back('{gmii_tx_data, gmii_tx_en, gmii_tx_er, frame_done, underrun, busy,
                        s_ready, s_valid, s_valid & s_ready & s_last});
  end

  task automatic build_table();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  // Expected wire bytes for one frame: preamble, SFD, body (padded), FCS LSB first.
  task automatic model_frame(input logic [7:0] pl[$], output logic [7:0] ex[$]);
    logic [31:0] crc;
    logic [7:0]  body[$];
    body = pl;
    if (PAD) while (body.size() < MINF) body.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    foreach (body[k]) crc = crc_tab[crc[7:0] ^ body[k]] ^ (crc >> 8);
    crc = ~crc;
    ex.delete();
    repeat (7) ex.push_back(8'h55);
    ex.push_back(8'hD5);
    foreach (body[k]) ex.push_back(body[k]);
    for (int k = 0; k < 4; k++) ex.push_back(crc[8*k +: 8]);
  endtask

  task automatic rand_payload(input int n, output logic [7:0] pl[$], output bit lst[$]);
    pl.delete(); lst.delete();
    for (int k = 0; k < n; k++) begin
      pl.push_back(8'($urandom_range(0, 255)));
      lst.push_back(k == n - 1);
    end
  endtask

  // Present bytes with the valid/ready handshake; stop early at drop_at.
  task automatic drive(input logic [7:0] b[$], input bit l[$], input int drop_at, output bit ok);
    int i; int g; bit acc;
    i = 0; g = 0; ok = 1'b1;
    @(posedge gmii_tx_clk); #1;
    while (i < b.size()) begin
      if (i == drop_at) break;
      s_valid = 1'b1; s_data = b[i]; s_last = l[i];
      #1 acc = s_ready;
      @(posedge gmii_tx_clk); #1;
      if (acc) i++;
      g++;
      if (g > 4000) begin ok = 1'b0; break; end
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
  endtask

  task automatic finish_capture(output bit ok);
    int g;
    g = 0;
    while (busy && g < 3000) begin @(posedge gmii_tx_clk); #1; g++; end
    ok = !busy;
    repeat (3) @(posedge gmii_tx_clk);
    #1 rec_on = 1'b0;
  endtask

  task automatic find_runs();
    int j;
    run_st.delete(); run_ln.delete();
    for (int i = 0; i < rec_q.size(); i++) begin
      if (rec_q[i].en && (i == 0 || !rec_q[i-1].en)) begin
        j = i;
        while (j < rec_q.size() && rec_q[j].en) j++;
        run_st.push_back(i);
        run_ln.push_back(j - i);
      end
    end
  endtask

  function automatic int count_field(input int sel);
    int c;
    c = 0;
    foreach (rec_q[i]) begin
      case (sel)
        0: c += int'(rec_q[i].fd);
        1: c += int'(rec_q[i].ur);
        2: c += int'(rec_q[i].er);
        default: c += int'(rec_q[i].en);
      endcase
    end
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1;
    #13;
    checks++; if (gmii_tx_data !== 8'h00) $display("FAIL reset_data: got %h need 00", gmii_tx_data); else passes++;
    checks++; if (gmii_tx_en !== 1'b0) $display("FAIL reset_en: got %b need 0", gmii_tx_en); else passes++;
    checks++; if (gmii_tx_er !== 1'b0) $display("FAIL reset_er: got %b need 0", gmii_tx_er); else passes++;
    checks++; if (s_ready !== 1'b0) $display("FAIL reset_ready: got %b need 0", s_ready); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b need 0", busy); else passes++;
    checks++; if ({frame_done, underrun} !== 2'b00) $display("FAIL reset_pulses: got %b need 00", {frame_done, underrun}); else passes++;
    s_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (4) @(posedge gmii_tx_clk);
    #1;
    checks++; if (busy !== 1'b0 || gmii_tx_en !== 1'b0) $display("FAIL idle_hold: got busy=%b en=%b need 0 0", busy, gmii_tx_en); else passes++;
  endtask

  task automatic test_known_vector();
    logic [7:0] pl[$]; bit lst[$]; logic [7:0] ex[$];
    bit ok1, ok2; int bad, i0, j, idle; logic [31:0] fcs;
    for (int k = 0; k < 9; k++) begin pl.push_back(8'h31 + 8'(k)); lst.push_back(k == 8); end
    model_frame(pl, ex);
    rec_q.delete(); rec_on = 1'b1;
    drive(pl, lst, -1, ok1);
    finish_capture(ok2);
    find_runs();
    checks++;
    if (!(ok1 && ok2) || run_ln.size() != 1) $display("FAIL kv_runs: got %0d runs ok=%b%b need 1 run", run_ln.size(), ok1, ok2);
    else passes++;
    if (run_ln.size() > 0) begin
      bad = -1;
      for (int k = 0; k < ex.size(); k++)
        if (k >= run_ln[0] || rec_q[run_st[0]+k].d !== ex[k]) begin bad = k; break; end
      checks++;
      if (run_ln[0] != ex.size() || bad >= 0) $display("FAIL kv_bytes: got len %0d first bad %0d need len %0d", run_ln[0], bad, ex.size());
      else passes++;
      if (!PAD && run_ln[0] >= 21) begin
        fcs = {rec_q[run_st[0]+17].d, rec_q[run_st[0]+18].d, rec_q[run_st[0]+19].d, rec_q[run_st[0]+20].d};
        checks++; if (fcs !== 32'h2639F4CB) $display("FAIL kv_fcs: got %h need 2639f4cb", fcs); else passes++;
      end
      i0 = -1;
      foreach (rec_q[k]) if (rec_q[k].sv && i0 < 0) i0 = k;
      checks++; if (run_st[0] != i0 + 1) $display("FAIL kv_latency: got preamble at %0d need %0d", run_st[0], i0 + 1); else passes++;
      j = run_st[0] + run_ln[0]; idle = 0;
      while (j < rec_q.size() && rec_q[j].bz && !rec_q[j].en) begin idle++; j++; end
      checks++; if (idle != IFG) $display("FAIL kv_ifg: got %0d need %0d", idle, IFG); else passes++;
      j = run_st[0] + run_ln[0];
      checks++;
      if (count_field(0) != 1 || j >= rec_q.size() || rec_q[j].fd !== 1'b1)
        $display("FAIL kv_frame_done: got %0d pulses need 1 on first gap cycle", count_field(0));
      else passes++;
    end
    checks++; if (count_field(2) != 0) $display("FAIL kv_no_er: got %0d er cycles need 0", count_field(2)); else passes++;
  endtask

  task automatic test_random_frames();
    int lens[$]; logic [7:0] pl[$]; bit lst[$]; logic [7:0] ex[$];
    bit ok1, ok2; int bad;
    lens = '{1, 42, 59, 60, 61, 0};
    lens[5] = $urandom_range(2, 90);
    foreach (lens[f]) begin
      rand_payload(lens[f], pl, lst);
      model_frame(pl, ex);
      rec_q.delete(); rec_on = 1'b1;
      drive(pl, lst, -1, ok1);
      finish_capture(ok2);
      find_runs();
      checks++;
      if (!(ok1 && ok2) || run_ln.size() != 1) $display("FAIL rand_runs len=%0d: got %0d runs need 1", lens[f], run_ln.size());
      else passes++;
      if (run_ln.size() > 0) begin
        bad = -1;
        for (int k = 0; k < ex.size(); k++)
          if (k >= run_ln[0] || rec_q[run_st[0]+k].d !== ex[k]) begin bad = k; break; end
        checks++;
        if (run_ln[0] != ex.size() || bad >= 0)
          $display("FAIL rand_bytes len=%0d: got run %0d first bad %0d need run %0d", lens[f], run_ln[0], bad, ex.size());
        else passes++;
      end
      checks++;
      if (count_field(0) != 1 || count_field(1) != 0)
        $display("FAIL rand_pulses len=%0d: got done=%0d underrun=%0d need 1 0", lens[f], count_field(0), count_field(1));
      else passes++;
    end
  endtask

  task automatic test_long_100();
    logic [7:0] pl[$]; bit lst[$]; logic [7:0] ex[$];
    bit ok1, ok2; int bad, ia;
    rand_payload(100, pl, lst);
    model_frame(pl, ex);
    rec_q.delete(); rec_on = 1'b1;
    drive(pl, lst, -1, ok1);
    finish_capture(ok2);
    checks++; if (!(ok1 && ok2) || count_field(3) != 112) $display("FAIL long_en_cycles: got %0d need 112", count_field(3)); else passes++;
    find_runs();
    if (run_ln.size() > 0) begin
      bad = -1;
      for (int k = 0; k < ex.size(); k++)
        if (k >= run_ln[0] || rec_q[run_st[0]+k].d !== ex[k]) begin bad = k; break; end
      checks++; if (bad >= 0) $display("FAIL long_bytes: got first bad %0d need none", bad); else passes++;
    end
    ia = -1;
    foreach (rec_q[k]) if (rec_q[k].acc_last) ia = k;
    checks++;
    if (ia < 0 || ia + 1 >= rec_q.size() || rec_q[ia+1].rdy !== 1'b0)
      $display("FAIL long_ready_fall: got last-accept at %0d, ready after not 0", ia);
    else passes++;
  endtask

  task automatic test_underrun();
    logic [7:0] pl[$]; bit lst[$]; logic [7:0] ex[$];
    bit ok1, ok2; int bad, e, j, idle;
    rand_payload(30, pl, lst);
    model_frame(pl, ex);
    rec_q.delete(); rec_on = 1'b1;
    drive(pl, lst, 20, ok1);
    finish_capture(ok2);
    find_runs();
    checks++;
    if (!(ok1 && ok2) || run_ln.size() != 1 || run_ln[0] != 29)
      $display("FAIL ur_run: got %0d runs first len %0d need 1 run of 29", run_ln.size(), run_ln.size() > 0 ? run_ln[0] : -1);
    else passes++;
    if (run_ln.size() > 0 && run_ln[0] >= 29) begin
      bad = -1;
      for (int k = 0; k < 28; k++) if (rec_q[run_st[0]+k].d !== ex[k]) begin bad = k; break; end
      checks++; if (bad >= 0) $display("FAIL ur_bytes: got first bad %0d need none", bad); else passes++;
      e = run_st[0] + 28;
      checks++;
      if ({rec_q[e].d, rec_q[e].er, rec_q[e].ur} !== {8'h00, 1'b1, 1'b1})
        $display("FAIL ur_err_cycle: got d=%h er=%b ur=%b need 00 1 1", rec_q[e].d, rec_q[e].er, rec_q[e].ur);
      else passes++;
      j = run_st[0] + run_ln[0]; idle = 0;
      while (j < rec_q.size() && rec_q[j].bz && !rec_q[j].en) begin idle++; j++; end
      checks++; if (idle != IFG) $display("FAIL ur_ifg: got %0d need %0d", idle, IFG); else passes++;
    end
    checks++;
    if (count_field(1) != 1 || count_field(0) != 0)
      $display("FAIL ur_pulses: got underrun=%0d done=%0d need 1 0", count_field(1), count_field(0));
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] p1[$], p2[$], all[$]; bit l1[$], l2[$], la[$]; logic [7:0] e1[$], e2[$];
    bit ok1, ok2; int bad, gap;
    rand_payload(64, p1, l1);
    rand_payload(70, p2, l2);
    model_frame(p1, e1);
    model_frame(p2, e2);
    all = {p1, p2}; la = {l1, l2};
    rec_q.delete(); rec_on = 1'b1;
    drive(all, la, -1, ok1);
    finish_capture(ok2);
    find_runs();
    checks++;
    if (!(ok1 && ok2) || run_ln.size() != 2) $display("FAIL b2b_runs: got %0d need 2", run_ln.size());
    else passes++;
    if (run_ln.size() == 2) begin
      gap = run_st[1] - (run_st[0] + run_ln[0]);
      checks++; if (gap != IFG) $display("FAIL b2b_gap: got %0d need %0d", gap, IFG); else passes++;
      bad = -1;
      for (int k = 0; k < e1.size(); k++)
        if (k >= run_ln[0] || rec_q[run_st[0]+k].d !== e1[k]) begin bad = k; break; end
      for (int k = 0; k < e2.size() && bad < 0; k++)
        if (k >= run_ln[1] || rec_q[run_st[1]+k].d !== e2[k]) begin bad = 1000 + k; break; end
      checks++; if (bad >= 0) $display("FAIL b2b_bytes: got first bad %0d need none", bad); else passes++;
    end
    checks++; if (count_field(0) != 2) $display("FAIL b2b_done: got %0d need 2", count_field(0)); else passes++;
  endtask

  task automatic test_reset_in_fcs();
    logic [7:0] pl[$]; bit lst[$]; logic [7:0] ex[$];
    bit ok1, ok2; int bad;
    rand_payload(64, pl, lst);
    model_frame(pl, ex);
    drive(pl, lst, -1, ok1);
    @(posedge gmii_tx_clk); #2;
    checks++;
    if (!ok1 || gmii_tx_en !== 1'b1 || gmii_tx_data !== ex[72])
      $display("FAIL rst_pre_fcs: got en=%b d=%h need 1 %h", gmii_tx_en, gmii_tx_data, ex[72]);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gmii_tx_data, gmii_tx_en, gmii_tx_er, busy, s_ready, frame_done, underrun} !== 14'h0)
      $display("FAIL rst_async: got d=%h en=%b er=%b busy=%b rdy=%b need all 0", gmii_tx_data, gmii_tx_en, gmii_tx_er, busy, s_ready);
    else passes++;
    #6 rst_n = 1'b1;
    rand_payload(50, pl, lst);
    model_frame(pl, ex);
    rec_q.delete(); rec_on = 1'b1;
    drive(pl, lst, -1, ok1);
    finish_capture(ok2);
    find_runs();
    checks++;
    if (!(ok1 && ok2) || run_ln.size() != 1) $display("FAIL rst_next_runs: got %0d need 1", run_ln.size());
    else passes++;
    if (run_ln.size() > 0) begin
      bad = -1;
      for (int k = 0; k < ex.size(); k++)
        if (k >= run_ln[0] || rec_q[run_st[0]+k].d !== ex[k]) begin bad = k; break; end
      checks++;
      if (run_ln[0] != ex.size() || bad >= 0) $display("FAIL rst_next_bytes: got len %0d first bad %0d need len %0d", run_ln[0], bad, ex.size());
      else passes++;
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_known_vector();
    test_random_frames();
    test_long_100();
    test_underrun();
    test_back_to_back();
    test_reset_in_fcs();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
